// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status-register bit positions and FSM encoding for the
// SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDCR = 8'h15;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DIN,
        ST_DOUT,
        ST_IGNORE,
        ST_SWEEP
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings cs_n/sclk/si into the clk domain and produces single-cycle edge strobes.
// cs_n rises are only accepted after three consecutive synchronized high samples.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic sclk,
    input  logic si,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic si_s,
    output logic cs_s
);
    logic [1:0] cs_sync;
    logic [1:0] sclk_sync;
    logic [1:0] si_sync;
    logic       sclk_d;
    logic       cs_filt;
    logic       cs_filt_d;
    logic [1:0] hi_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= 2'b11;
            sclk_sync <= '0;
            si_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_filt   <= 1'b1;
            cs_filt_d <= 1'b1;
            hi_cnt    <= '0;
        end else begin
            cs_sync   <= {cs_sync[0], cs_n};
            sclk_sync <= {sclk_sync[0], sclk};
            si_sync   <= {si_sync[0], si};
            sclk_d    <= sclk_sync[1];
            cs_filt_d <= cs_filt;
            // Deselect is glitch-filtered; select takes effect immediately.
            if (!cs_sync[1]) begin
                cs_filt <= 1'b0;
                hi_cnt  <= '0;
            end else if (!cs_filt) begin
                if (hi_cnt == 2'd2) cs_filt <= 1'b1;
                else                hi_cnt  <= hi_cnt + 2'd1;
            end
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign cs_fall   = cs_filt_d & ~cs_filt;
    assign cs_rise   = ~cs_filt_d & cs_filt;
    assign si_s      = si_sync[1];
    assign cs_s      = cs_filt;

endmodule

// File: rtl/spi_flash_responder.sv
// Single-lane SPI mode-0 flash target backed by a small byte array, answering
// RDID/RDSR/RDCR/WREN/WRDI/READ/PP/SE.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          MEM_AW   = 8,
    parameter int          BUSY_CYC = 1024,
    parameter logic [23:0] ID_BYTES = 24'hC22017,
    parameter logic [7:0]  CR_INIT  = 8'h07
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic sclk,
    input  logic si,
    output logic so,
    output logic so_oe,
    output logic wip,
    output logic wel
);
    localparam int                DEPTH     = 1 << MEM_AW;
    localparam int                BW        = $clog2(BUSY_CYC);
    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(8'hFF);

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, si_s, cs_s;

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .si        (si),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .si_s      (si_s),
        .cs_s      (cs_s)
    );

    state_t            state, state_nxt;
    logic [MEM_AW-1:0] rx;
    logic              step;
    logic [2:0]        bit_cnt;
    logic [5:0]        tot_bits;
    logic [7:0]        opcode;
    logic [MEM_AW-1:0] idx, idx_pp_nxt, sweep_idx;
    logic              data_seen;
    logic [7:0]        tx_sh;
    logic [2:0]        tx_cnt;
    logic [1:0]        id_sel;
    logic [BW-1:0]     busy_cnt;
    logic [7:0]        mem [DEPTH];

    logic [7:0] sr, out_byte, cmd_op;
    logic       byte_done, addr_done, cmd_dout, cmd_addr, cmd_wr, blocked;
    logic       end_xfer, pp_commit, se_commit, prog_we;

    // Decisions run one clk after the sclk rise so rx already holds the new bit.
    always_comb begin
        sr          = '0;
        sr[SR_WIP]  = wip;
        sr[SR_WEL]  = wel;
        cmd_op      = rx[7:0];
        byte_done   = step && (bit_cnt == 3'd7);
        addr_done   = step && (tot_bits == 6'd31);
        cmd_dout    = (cmd_op == OP_RDID) || (cmd_op == OP_RDSR) || (cmd_op == OP_RDCR);
        cmd_addr    = (cmd_op == OP_READ) || (cmd_op == OP_PP) || (cmd_op == OP_SE);
        cmd_wr      = (cmd_op == OP_WREN) || (cmd_op == OP_WRDI);
        blocked     = wip && (cmd_op != OP_RDSR);
        end_xfer    = cs_rise && (state != ST_IDLE) && (state != ST_SWEEP);
        pp_commit   = end_xfer && (state == ST_DIN) && (opcode == OP_PP) && wel && data_seen;
        se_commit   = end_xfer && (state == ST_IGNORE) && (opcode == OP_SE) && wel
                      && (tot_bits == 6'd32);
        prog_we     = (state == ST_DIN) && byte_done && wel;
        idx_pp_nxt  = (idx & ~PAGE_MASK) | ((idx + 1'b1) & PAGE_MASK);
        case (opcode)
            OP_RDID: begin
                case (id_sel)
                    2'd0:    out_byte = ID_BYTES[23:16];
                    2'd1:    out_byte = ID_BYTES[15:8];
                    default: out_byte = ID_BYTES[7:0];
                endcase
            end
            OP_RDSR: out_byte = sr;
            OP_RDCR: out_byte = CR_INIT;
            default: out_byte = mem[idx];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (byte_done) begin
                    if (blocked)       state_nxt = ST_IGNORE;
                    else if (cmd_dout) state_nxt = ST_DOUT;
                    else if (cmd_addr) state_nxt = ST_ADDR;
                    else               state_nxt = ST_IGNORE;
                end
            end
            ST_ADDR: begin
                if (addr_done) begin
                    if (opcode == OP_READ)    state_nxt = ST_DOUT;
                    else if (opcode == OP_PP) state_nxt = ST_DIN;
                    else                      state_nxt = ST_IGNORE;
                end
            end
            ST_SWEEP: if (sweep_idx == '1) state_nxt = cs_s ? ST_IDLE : ST_CMD;
            default: ;
        endcase
        if (end_xfer) state_nxt = se_commit ? ST_SWEEP : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_SWEEP;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx        <= '0;
            step      <= 1'b0;
            bit_cnt   <= '0;
            tot_bits  <= '0;
            opcode    <= '0;
            idx       <= '0;
            sweep_idx <= '0;
            data_seen <= 1'b0;
            tx_sh     <= '0;
            tx_cnt    <= '0;
            id_sel    <= '0;
            so        <= 1'b0;
            so_oe     <= 1'b0;
            wip       <= 1'b1;
            wel       <= 1'b0;
            busy_cnt  <= BW'(BUSY_CYC - 1);
        end else begin
            step <= sclk_rise;
            if (sclk_rise) rx <= {rx[MEM_AW-2:0], si_s};

            if (wip) begin
                if (busy_cnt == '0) wip      <= 1'b0;
                else                busy_cnt <= busy_cnt - 1'b1;
            end
            if (pp_commit || se_commit) begin
                wip      <= 1'b1;
                busy_cnt <= BW'(BUSY_CYC - 1);
                wel      <= 1'b0;
            end

            if (state == ST_SWEEP) sweep_idx <= sweep_idx + 1'b1;

            if (state == ST_IDLE || state == ST_SWEEP) begin
                bit_cnt   <= '0;
                tot_bits  <= '0;
                tx_cnt    <= '0;
                id_sel    <= '0;
                data_seen <= 1'b0;
                so        <= 1'b0;
                so_oe     <= 1'b0;
            end else begin
                if (step) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (tot_bits != 6'h3F) tot_bits <= tot_bits + 6'd1;
                end
                if (state == ST_CMD && byte_done)
                    opcode <= ((cmd_dout || cmd_addr || cmd_wr) && !blocked) ? cmd_op : 8'h00;
                if (state == ST_ADDR && addr_done) idx <= rx;
                if (state == ST_DIN && byte_done) begin
                    idx       <= idx_pp_nxt;
                    data_seen <= 1'b1;
                end
                if (state == ST_DOUT && sclk_fall) begin
                    so_oe <= 1'b1;
                    if (tx_cnt == '0) begin
                        so     <= out_byte[7];
                        tx_sh  <= {out_byte[6:0], 1'b0};
                        tx_cnt <= 3'd7;
                        id_sel <= (id_sel == 2'd2) ? 2'd0 : id_sel + 2'd1;
                        if (opcode == OP_READ) idx <= idx + 1'b1;
                    end else begin
                        so     <= tx_sh[7];
                        tx_sh  <= {tx_sh[6:0], 1'b0};
                        tx_cnt <= tx_cnt - 3'd1;
                    end
                end
                if (end_xfer) begin
                    so_oe <= 1'b0;
                    if (opcode == OP_WREN && tot_bits == 6'd8) wel <= 1'b1;
                    if (opcode == OP_WRDI && tot_bits == 6'd8) wel <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_SWEEP) mem[sweep_idx] <= 8'hFF;
        else if (prog_we)      mem[idx]       <= mem[idx] & rx[7:0];
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: drives SPI mode-0 transactions and
// checks responses against hand-computed values.
module tb_spi_flash_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n  = 1'b1;
    logic sclk  = 1'b0;
    logic si    = 1'b0;
    logic so, so_oe, wip, wel;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rb;
    logic       oe_seen;
    int         cnt;

    spi_flash_responder #(
        .MEM_AW   (8),
        .BUSY_CYC (1024),
        .ID_BYTES (24'hC22017),
        .CR_INIT  (8'h07)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs_n  (cs_n),
        .sclk  (sclk),
        .si    (si),
        .so    (so),
        .so_oe (so_oe),
        .wip   (wip),
        .wel   (wel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #5;
    endtask

    task automatic xfer(input logic [7:0] d, input int nbits, output logic [7:0] q);
        q = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            si = d[i];
            #40;
            sclk = 1'b1;
            q[i] = so;
            oe_seen = oe_seen | so_oe;
            #40;
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        oe_seen = 1'b0;
        cs_n = 1'b0;
        #60;
    endtask

    task automatic cs_stop();
        #40;
        cs_n = 1'b1;
        #100;
    endtask

    task automatic cmd_addr(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] q;
        xfer(op, 8, q);
        xfer(addr[23:16], 8, q);
        xfer(addr[15:8], 8, q);
        xfer(addr[7:0], 8, q);
    endtask

    task automatic simple_cmd(input logic [7:0] op);
        logic [7:0] q;
        cs_start();
        xfer(op, 8, q);
        cs_stop();
    endtask

    task automatic rdsr(output logic [7:0] q);
        logic [7:0] d;
        cs_start();
        xfer(8'h05, 8, d);
        xfer(8'h00, 8, q);
        cs_stop();
    endtask

    initial begin
        // Reset state
        #20;
        check("rst_so", so, 1'b0);
        check("rst_so_oe", so_oe, 1'b0);
        check("rst_wip", wip, 1'b1);
        check("rst_wel", wel, 1'b0);
        #10;
        rst_n = 1'b1;
        idle(1);
        check("rst_wip_after_release", wip, 1'b1);
        idle(1100);
        check("init_wip_done", wip, 1'b0);
        rdsr(rb);
        check("rdsr_after_init", rb, 8'h00);

        // READ after init sweep
        cs_start();
        cmd_addr(8'h03, 24'h000010);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, 8, rb);
            check("read_init_ff", rb, 8'hFF);
        end
        check("read_oe_seen", oe_seen, 1'b1);
        cs_stop();
        check("oe_drop_after_cs", so_oe, 1'b0);

        // RDID with wrap, plus a 1-clk cs_n glitch that must be ignored
        cs_start();
        xfer(8'h9F, 8, rb);
        xfer(8'h00, 8, rb);
        check("rdid_b0", rb, 8'hC2);
        cs_n = 1'b1;
        #10;
        cs_n = 1'b0;
        #10;
        xfer(8'h00, 8, rb);
        check("rdid_b1_after_glitch", rb, 8'h20);
        xfer(8'h00, 8, rb);
        check("rdid_b2", rb, 8'h17);
        xfer(8'h00, 8, rb);
        check("rdid_wrap", rb, 8'hC2);
        cs_stop();

        cs_start();
        xfer(8'h15, 8, rb);
        xfer(8'h00, 8, rb);
        check("rdcr", rb, 8'h07);
        cs_stop();

        // WREN then page program across the page boundary
        simple_cmd(8'h06);
        check("wel_pin_after_wren", wel, 1'b1);
        rdsr(rb);
        check("rdsr_wel", rb, 8'h02);
        cs_start();
        cmd_addr(8'h02, 24'h0000FE);
        xfer(8'hA5, 8, rb);
        xfer(8'h5A, 8, rb);
        xfer(8'h3C, 8, rb);
        cs_stop();
        rdsr(rb);
        check("rdsr_pp_busy", rb, 8'h01);
        idle(1100);
        rdsr(rb);
        check("rdsr_pp_done", rb, 8'h00);
        cs_start();
        cmd_addr(8'h03, 24'h0000FE);
        xfer(8'h00, 8, rb);
        check("read_fe", rb, 8'hA5);
        xfer(8'h00, 8, rb);
        check("read_ff", rb, 8'h5A);
        xfer(8'h00, 8, rb);
        check("read_00_wrap", rb, 8'h3C);
        cs_stop();

        // PP without WREN
        cs_start();
        cmd_addr(8'h02, 24'h000020);
        xfer(8'h00, 8, rb);
        cs_stop();
        check("pp_nowel_wip", wip, 1'b0);
        cs_start();
        cmd_addr(8'h03, 24'h000020);
        xfer(8'h00, 8, rb);
        check("pp_nowel_mem", rb, 8'hFF);
        cs_stop();

        // PP with only 5 data bits
        simple_cmd(8'h06);
        cs_start();
        cmd_addr(8'h02, 24'h000030);
        xfer(8'h00, 5, rb);
        cs_stop();
        check("pp_partial_wip", wip, 1'b0);
        check("pp_partial_wel", wel, 1'b1);
        cs_start();
        cmd_addr(8'h03, 24'h000030);
        xfer(8'h00, 8, rb);
        check("pp_partial_mem", rb, 8'hFF);
        cs_stop();

        // Valid PP, then READ while busy
        cs_start();
        cmd_addr(8'h02, 24'h000050);
        xfer(8'h0F, 8, rb);
        cs_stop();
        check("pp50_wip", wip, 1'b1);
        check("pp50_wel_cleared", wel, 1'b0);
        cs_start();
        cmd_addr(8'h03, 24'h000050);
        xfer(8'h00, 8, rb);
        xfer(8'h00, 8, rb);
        check("busy_read_oe", oe_seen, 1'b0);
        cs_stop();
        idle(1100);
        cs_start();
        cmd_addr(8'h03, 24'h000050);
        xfer(8'h00, 8, rb);
        check("read_50", rb, 8'h0F);
        cs_stop();

        // Sector erase: WIP length and full-array FF
        simple_cmd(8'h06);
        cs_start();
        cmd_addr(8'h20, 24'h000040);
        #40;
        cs_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40 && !wip; k++) @(negedge clk);
        while (wip && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        check("se_wip_len", cnt, 1024);
        check("se_wel_cleared", wel, 1'b0);
        idle(5);
        cs_start();
        cmd_addr(8'h03, 24'h000000);
        for (int i = 0; i < 256; i++) begin
            xfer(8'h00, 8, rb);
            check("se_byte_ff", rb, 8'hFF);
        end
        cs_stop();

        // Reset in the middle of a READ
        cs_start();
        cmd_addr(8'h03, 24'h000000);
        xfer(8'h00, 8, rb);
        check("mid_read_oe", so_oe, 1'b1);
        #23;
        rst_n = 1'b0;
        #1;
        check("rst_mid_oe", so_oe, 1'b0);
        check("rst_mid_so", so, 1'b0);
        #6;
        cs_n = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("rst_mid_wip", wip, 1'b1);
        idle(300);
        rdsr(rb);
        check("rst_mid_rdsr_busy", rb, 8'h01);
        idle(1100);
        rdsr(rb);
        check("rst_mid_rdsr_done", rb, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable single-lane SPI flash target (SPI mode 0, MSB first) that answers the command subset issued by `spi_flash`: RDID, RDSR, RDCR, WREN, WRDI, READ, PP, SE.
- Backed by a small internal byte array and used as a lightweight stand-in for the vendor flash model in fast regressions and FPGA loopback.
- Oversamples `sclk`/`cs_n`/`si` in its own `clk` domain.
- Drives `so` with an explicit output enable.

## Interface
- `MEM_AW`, 8: memory address width; depth = 2^MEM_AW bytes, legal range 8..12.
- `BUSY_CYC`, 1024: clk cycles WIP stays set after PP/SE/reset sweep; must be ≥ 2^MEM_AW.
- `ID_BYTES`, 24'hC22017: RDID response, sent MSB byte first.
- `CR_INIT`, 8'h07: configuration register value returned by RDCR.
- `clk` input 1: system clock, must be ≥ 4× SCLK frequency.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `cs_n` input 1: chip select from initiator, active-low.
- `sclk` input 1: serial clock from initiator, idle low.
- `si` input 1: serial data in.
- `so` output 1: serial data out.
- `so_oe` output 1: high while `so` carries response data.
- `wip` output 1: mirror of SR[0].
- `wel` output 1: mirror of SR[1].

## Operation
- `cs_n`, `sclk` and `si` pass through 2-FF synchronizers. Edge detect runs on the synchronized values.
- An SCLK rise samples `si`. An SCLK fall shifts `so`.
- FSM states: IDLE, CMD, ADDR, DIN, DOUT, IGNORE, SWEEP.
  - IDLE → CMD on `cs_n` fall.
  - CMD: collects 8 bits, then branches on the opcode:
    - 9F/05/15 → DOUT.
    - 03/02/20 → ADDR.
    - 06/04 → IGNORE; WEL is set/cleared at the `cs_n` rise.
    - Unknown opcode → IGNORE.
  - While WIP=1, every opcode except 05 → IGNORE.
  - ADDR: collects 24 bits. Memory index = addr[MEM_AW-1:0]. Then 03 → DOUT, 02 → DIN, 20 → IGNORE.
  - DOUT sources:
    - RDID: cycles through the 3 ID bytes, wrapping.
    - RDSR: repeats SR.
    - RDCR: repeats CR.
    - READ: mem[idx], with idx incrementing per byte and wrapping at 2^MEM_AW.
  - DIN (PP): each completed byte does mem[idx] ← mem[idx] & byte. idx[7:0] increments and wraps within the 256-byte page. Programming happens only if WEL=1.
  - Any state returns to IDLE on `cs_n` rise.
- Actions at `cs_n` rise:
  - A partial byte is discarded.
  - PP with WEL=1 and ≥1 complete data byte: set WIP, clear WEL.
  - SE with WEL=1 and exactly 32 bits received: enter SWEEP, set WIP, clear WEL.
  - WREN/WRDI take effect only if exactly 8 bits were received.
- SWEEP writes 8'hFF to one byte per clk across the whole array (the sector covers all of memory since MEM_AW ≤ 12). WIP stays 1 for BUSY_CYC cycles total. The FSM then returns to IDLE (or CMD if `cs_n` is already low).
- SR layout: bit0 WIP, bit1 WEL, all other bits 0.

## Timing
- Reset values: `so`=0, `so_oe`=0, SR=8'h01 (WIP set by the init sweep), FSM=SWEEP.
- After reset, the memory reads all 8'hFF after BUSY_CYC cycles.
- First output bit is valid on `so` within 3 clk after the SCLK fall that follows the 8th (or 32nd) input bit's rise.
- `so_oe` rises on that same SCLK fall and drops within 3 clk of the synchronized `cs_n` rise.
- WIP rises within 3 clk of the `cs_n` rise and counts exactly BUSY_CYC cycles.
- A `cs_n` pulse is ignored unless it lasts ≥ 3 clk high.
- Reset mid-transfer aborts the transfer immediately and restarts the init sweep.

## Structure
- `spi_flash_pkg` holds:
  - opcode localparams (OP_RDID 8'h9F, OP_RDSR 8'h05, OP_RDCR 8'h15, OP_WREN 8'h06, OP_WRDI 8'h04, OP_READ 8'h03, OP_PP 8'h02, OP_SE 8'h20);
  - SR bit indices;
  - the FSM state encoding.
- Sub-module `spi_edge_sync` contains the synchronizers and emits `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`, `si_s`.

## Test plan
- Reset, wait BUSY_CYC, RDSR → 8'h00. READ addr 0x000010, 4 bytes → FF FF FF FF.
- RDID, 4 bytes → C2 20 17 C2. RDCR → 07.
- WREN then RDSR → 02. PP addr 0x0000FE, data A5 5A 3C → mem[FE]=A5, mem[FF]=5A, mem[00]=3C (page wrap). RDSR during busy → 01, and 00 after BUSY_CYC. READ FE, 3 bytes → A5 5A 3C.
- PP without WREN, addr 0x20, data 00 → READ 0x20 still FF. PP after WREN with `cs_n` rising after 5 data bits → memory unchanged and WIP stays 0.
- Issue READ while WIP=1 → `so_oe` stays 0. WREN then SE addr 0x40 → WIP=1 for BUSY_CYC cycles, then every byte reads FF.
- Assert `rst_n` low mid-READ → `so_oe`=0 within 1 clk. SR=01 after release, 00 after BUSY_CYC.
